// File: rtl/binary_guesser.sv
// -----------------------------------------------------------------------------
// binary_guesser
//
// Finds a hidden 7-bit target by binary search. Each clock in CHECK presents
// one guess on guess_number. The environment answers on result in the same
// cycle: 00 = hit, 01 = guess too high, 10 = guess too low, 11 = invalid.
// The search narrows the inclusive interval [lo, hi] until it hits the target.
// It ends in FAIL when the answers contradict each other, when the interval
// collapses, or when MAX_ATTEMPTS guesses have been used.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : begin a new search (honoured in IDLE, DONE, FAIL)
//   abort        : return to IDLE from any state, wins over start
//   result       : comparison of guess_number against the target
//   guess_number : current guess (registered)
//   guess_valid  : guess_number is a live guess awaiting result
//   busy         : search in progress (CHECK)
//   done         : target found (level, held in DONE)
//   fail         : search failed (level, held in FAIL)
//   found_number : located target, meaningful while done=1
//   attempts     : guesses issued in the current or last search
// -----------------------------------------------------------------------------
module binary_guesser #(
    parameter int MAX_ATTEMPTS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] result,
    output logic [6:0] guess_number,
    output logic       guess_valid,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [6:0] found_number,
    output logic [3:0] attempts
);

    localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);

    localparam logic [1:0] RES_HIT  = 2'b00;
    localparam logic [1:0] RES_HIGH = 2'b01;
    localparam logic [1:0] RES_LOW  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t     state_reg;
    logic [6:0] lo_reg;
    logic [6:0] hi_reg;

    // Midpoints of the next interval. The sums use 8 bits so that
    // 127 + 1 + 127 cannot wrap. When the guess was too high, the new interval
    // is [lo, guess-1]. That branch is only taken when guess > lo, so guess >= 1
    // and guess-1 never underflows.
    logic [7:0] sum_lower;
    logic [7:0] sum_upper;
    logic [6:0] mid_lower;
    logic [6:0] mid_upper;
    logic       at_limit;

    assign sum_lower = {1'b0, lo_reg} + {1'b0, guess_number} - 8'd1;
    assign sum_upper = {1'b0, guess_number} + 8'd1 + {1'b0, hi_reg};
    assign mid_lower = 7'(sum_lower >> 1);
    assign mid_upper = 7'(sum_upper >> 1);
    assign at_limit  = (attempts == MAX_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            lo_reg       <= 7'd0;
            hi_reg       <= 7'd127;
            guess_number <= 7'd0;
            guess_valid  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            found_number <= 7'd0;
            attempts     <= 4'd0;
        end else if (abort) begin
            // guess_number, attempts and found_number keep their values
            // so that software can still inspect the abandoned search.
            state_reg   <= ST_IDLE;
            guess_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        state_reg    <= ST_CHECK;
                        lo_reg       <= 7'd0;
                        hi_reg       <= 7'd127;
                        guess_number <= 7'd63;
                        guess_valid  <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        fail         <= 1'b0;
                        attempts     <= 4'd1;
                    end
                end

                ST_CHECK: begin
                    case (result)
                        RES_HIT: begin
                            state_reg    <= ST_DONE;
                            found_number <= guess_number;
                            guess_valid  <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end
                        RES_HIGH: begin
                            // An answer of "too high" at the lower bound means
                            // the interval is empty.
                            if (guess_number == lo_reg || at_limit) begin
                                state_reg   <= ST_FAIL;
                                guess_valid <= 1'b0;
                                busy        <= 1'b0;
                                fail        <= 1'b1;
                            end else begin
                                hi_reg       <= guess_number - 7'd1;
                                guess_number <= mid_lower;
                                attempts     <= attempts + 4'd1;
                            end
                        end
                        RES_LOW: begin
                            if (guess_number == hi_reg || at_limit) begin
                                state_reg   <= ST_FAIL;
                                guess_valid <= 1'b0;
                                busy        <= 1'b0;
                                fail        <= 1'b1;
                            end else begin
                                lo_reg       <= guess_number + 7'd1;
                                guess_number <= mid_upper;
                                attempts     <= attempts + 4'd1;
                            end
                        end
                        default: begin
                            state_reg   <= ST_FAIL;
                            guess_valid <= 1'b0;
                            busy        <= 1'b0;
                            fail        <= 1'b1;
                        end
                    endcase
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_guesser.sv
// -----------------------------------------------------------------------------
// tb_binary_guesser
//
// Two instances are used: dut_a has the default limit of 8 guesses and dut_b
// has a limit of 3. The result input is an oracle computed from a shared
// target and answer mode: 0 = honest, 1 = always "too high", 2 = always
// invalid. The reference model is a plain integer binary search over an
// interval.
// -----------------------------------------------------------------------------
module tb_binary_guesser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort;
    logic       start_a, start_b;
    logic [1:0] result_a, result_b;
    logic [6:0] guess_a, guess_b, found_a, found_b;
    logic       gv_a, gv_b, busy_a, busy_b, done_a, done_b, fail_a, fail_b;
    logic [3:0] att_a, att_b;

    logic [6:0] tgt;
    logic [1:0] mode;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    binary_guesser dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .result(result_a), .guess_number(guess_a), .guess_valid(gv_a),
        .busy(busy_a), .done(done_a), .fail(fail_a),
        .found_number(found_a), .attempts(att_a)
    );

    binary_guesser #(.MAX_ATTEMPTS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .result(result_b), .guess_number(guess_b), .guess_valid(gv_b),
        .busy(busy_b), .done(done_b), .fail(fail_b),
        .found_number(found_b), .attempts(att_b)
    );

    function automatic logic [1:0] oracle(input logic [6:0] g, input logic [6:0] t,
                                          input logic [1:0] m);
        if (m == 2'd1) return 2'b01;
        if (m == 2'd2) return 2'b11;
        if (g == t) return 2'b00;
        if (g > t) return 2'b01;
        return 2'b10;
    endfunction

    always_comb begin
        result_a = oracle(guess_a, tgt, mode);
        result_b = oracle(guess_b, tgt, mode);
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: each guess is the midpoint of the remaining interval.
    task automatic model(input int t, input int m, input int maxa,
                         output int q[$], output bit d, output bit f);
        int lo, hi, g, r;
        lo = 0; hi = 127; d = 0; f = 0; q = {};
        while (1) begin
            g = (lo + hi) / 2;
            q.push_back(g);
            r = (m == 1) ? 1 : (m == 2) ? 3 : (g == t) ? 0 : (g > t) ? 1 : 2;
            if (r == 0) begin d = 1; break; end
            if (r == 3) begin f = 1; break; end
            if ((r == 1 && g == lo) || (r == 2 && g == hi)) begin f = 1; break; end
            if (q.size() == maxa) begin f = 1; break; end
            if (r == 1) hi = g - 1; else lo = g + 1;
        end
    endtask

    // Pulse start, then collect one guess per cycle until done or fail.
    // poke >= 0 re-asserts start for one cycle that many cycles into CHECK.
    task automatic run_search(input bit sel, input int poke, output int q[$],
                              output int d, output int f, output int a,
                              output int fnd, output int last, output int gv_end);
        bit ended;
        q = {}; ended = 0;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (sel ? (done_b | fail_b) : (done_a | fail_a)) begin
                ended = 1;
                break;
            end
            if (sel ? gv_b : gv_a) q.push_back(int'(sel ? guess_b : guess_a));
            if (c == poke) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
        end
        if (!ended) check("search_timeout", 0, 1);
        d      = int'(sel ? done_b : done_a);
        f      = int'(sel ? fail_b : fail_a);
        a      = int'(sel ? att_b : att_a);
        fnd    = int'(sel ? found_b : found_a);
        last   = int'(sel ? guess_b : guess_a);
        gv_end = int'(sel ? gv_b : gv_a);
    endtask

    function automatic int seq_mismatch(input int act[$], input int exp[$]);
        if (act.size() != exp.size()) return 1000 + act.size();
        foreach (exp[i]) if (act[i] != exp[i]) return i + 1;
        return 0;
    endfunction

    // Runs one search and checks it in full against the model.
    task automatic model_search(input bit sel, input int t, input int m, input int poke,
                                output int d, output int f, output int a,
                                output int fnd, output int last);
        int q[$], mq[$], gv_end;
        bit md, mf;
        tgt = 7'(t); mode = 2'(m);
        model(t, m, sel ? 3 : 8, mq, md, mf);
        run_search(sel, poke, q, d, f, a, fnd, last, gv_end);
        check("guess_seq", seq_mismatch(q, mq), 0);
        check("done", d, int'(md));
        check("fail", f, int'(mf));
        check("attempts", a, mq.size());
        check("guess_valid_end", gv_end, 0);
        if (md) check("found", fnd, t);
        $display("[TB] search dut=%s target=%0d mode=%0d guesses=%0d done=%0d fail=%0d",
                 sel ? "b" : "a", t, m, q.size(), d, f);
    endtask

    typedef struct {
        bit sel;
        int t;
        int m;
        int exp_att;
        int exp_done;
        int exp_fail;
        int exp_last;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d, f, a, fnd, last, gv_end, att_before, found_before;
        int q[$], exp0[$], exp127[$];

        vecs[0] = '{0, 63,  0, 1, 1, 0, 63};
        vecs[1] = '{0, 0,   0, 7, 1, 0, 0};
        vecs[2] = '{0, 127, 0, 8, 1, 0, 127};
        vecs[3] = '{0, 64,  0, 7, 1, 0, 64};
        vecs[4] = '{0, 50,  1, 7, 0, 1, 0};
        vecs[5] = '{0, 50,  2, 1, 0, 1, 63};
        vecs[6] = '{1, 0,   0, 3, 0, 1, 15};
        vecs[7] = '{1, 100, 0, 3, 0, 1, 111};
        exp0   = '{63, 31, 15, 7, 3, 1, 0};
        exp127 = '{63, 95, 111, 119, 123, 125, 126, 127};

        rst_n = 1'b0; abort = 1'b0; start_a = 1'b0; start_b = 1'b0;
        tgt = 7'd0; mode = 2'd0;
        #1;
        check("rst_guess", int'(guess_a), 0);
        check("rst_gv", int'(gv_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_fail", int'(fail_a), 0);
        check("rst_found", int'(found_a), 0);
        check("rst_attempts", int'(att_a), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy_a), 0);

        // Table of directed searches.
        foreach (vecs[i]) begin
            model_search(vecs[i].sel, vecs[i].t, vecs[i].m, -1, d, f, a, fnd, last);
            check("vec_attempts", a, vecs[i].exp_att);
            check("vec_done", d, vecs[i].exp_done);
            check("vec_fail", f, vecs[i].exp_fail);
            check("vec_last_guess", last, vecs[i].exp_last);
        end

        // Literal guess sequences for the extreme targets.
        tgt = 7'd0; mode = 2'd0;
        run_search(0, -1, q, d, f, a, fnd, last, gv_end);
        check("seq_target0", seq_mismatch(q, exp0), 0);
        tgt = 7'd127;
        run_search(0, -1, q, d, f, a, fnd, last, gv_end);
        check("seq_target127", seq_mismatch(q, exp127), 0);

        // Every target resolves within 8 guesses.
        for (int t = 0; t < 128; t++) begin
            tgt = 7'(t); mode = 2'd0;
            run_search(0, -1, q, d, f, a, fnd, last, gv_end);
            check("sweep_done", d, 1);
            check("sweep_found", fnd, t);
            check("sweep_le8", int'(a <= 8), 1);
        end

        // start while searching is ignored.
        model_search(0, 127, 0, 2, d, f, a, fnd, last);

        // abort on the third guess.
        tgt = 7'd0; mode = 2'd0;
        found_before = int'(found_a);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        @(negedge clk); @(negedge clk);
        check("abort_third_guess", int'(guess_a), 15);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("abort_busy", int'(busy_a), 0);
        check("abort_gv", int'(gv_a), 0);
        check("abort_attempts", int'(att_a), 3);
        check("abort_guess_hold", int'(guess_a), 15);
        check("abort_found_hold", int'(found_a), found_before);
        @(negedge clk);
        check("abort_stays_idle", int'(busy_a), 0);
        $display("[TB] abort at third guess");

        // abort and start together from DONE: abort wins.
        model_search(0, 40, 0, -1, d, f, a, fnd, last);
        att_before = int'(att_a);
        abort = 1'b1; start_a = 1'b1; @(negedge clk);
        abort = 1'b0; start_a = 1'b0;
        check("abstart_done_clr", int'(done_a), 0);
        check("abstart_busy", int'(busy_a), 0);
        check("abstart_gv", int'(gv_a), 0);
        check("abstart_att_hold", int'(att_a), att_before);
        $display("[TB] abort+start from done");

        // Reset in the middle of a search.
        tgt = 7'd127; mode = 2'd0;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_guess", int'(guess_a), 0);
        check("midrst_gv", int'(gv_a), 0);
        check("midrst_busy", int'(busy_a), 0);
        check("midrst_attempts", int'(att_a), 0);
        check("midrst_found", int'(found_a), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("postrst_idle", int'(busy_a), 0);
        model_search(0, 127, 0, -1, d, f, a, fnd, last);
        $display("[TB] reset mid-search");

        // Random searches on both instances.
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            model_search(bit'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                         (r == 0) ? 1 : (r == 1) ? 2 : 0, -1, d, f, a, fnd, last);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
